// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction fetch controller:
//   - default address / instruction widths
//   - default first fetch address after reset
//   - fetch FSM state encoding
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

   localparam int          FC_ADDR_W   = 32;
   localparam int          FC_DATA_W   = 32;
   localparam logic [31:0] FC_RESET_PC = 32'h0000_0000;

   // S_REQ and S_CANCEL are the only states with a live memory request
   typedef enum logic [1:0] {
      S_BOOT   = 2'd0,
      S_REQ    = 2'd1,
      S_IDLE   = 2'd2,
      S_CANCEL = 2'd3
   } fetch_state_t;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_ctrl_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Two-entry prefetch FIFO of {pc, inst} pairs feeding decode.
// Entry 0 is always the head, so the head outputs come straight from flops.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   i_push, i_push_pc,   write a new {pc, inst} pair
//   i_push_inst
//   i_pop                consume the head (ignored when empty)
//   i_flush              discard every entry; wins over push and pop
//   o_head_pc/o_head_inst head entry
//   o_valid              queue not empty
//   o_count              number of occupied entries (0..2)
// -----------------------------------------------------------------------------
module fetch_buf
   import fetch_ctrl_pkg::*;
#(
   parameter int AW = FC_ADDR_W,
   parameter int DW = FC_DATA_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [AW-1:0] i_push_pc,
   input  logic [DW-1:0] i_push_inst,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic [AW-1:0] o_head_pc,
   output logic [DW-1:0] o_head_inst,
   output logic          o_valid,
   output logic [1:0]    o_count
);

   logic [AW-1:0] r_pc0;
   logic [DW-1:0] r_inst0;
   logic [AW-1:0] r_pc1;
   logic [DW-1:0] r_inst1;
   logic [1:0]    r_count;
   logic          w_pop_ok;

   // Qualify pop so an empty queue can never underflow
   always_comb begin
      w_pop_ok = 1'b0;
      if (r_count != 2'd0) begin
         w_pop_ok = i_pop;
      end else begin
         w_pop_ok = 1'b0;
      end
   end

   // Entry storage and occupancy; head lives in entry 0
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc0   <= {AW{1'b0}};
         r_inst0 <= {DW{1'b0}};
         r_pc1   <= {AW{1'b0}};
         r_inst1 <= {DW{1'b0}};
         r_count <= 2'd0;
      end else if (i_flush) begin
         r_count <= 2'd0;
      end else begin
         case ({i_push, w_pop_ok})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_pc0   <= i_push_pc;
                  r_inst0 <= i_push_inst;
                  r_count <= 2'd1;
               end else if (r_count == 2'd1) begin
                  r_pc1   <= i_push_pc;
                  r_inst1 <= i_push_inst;
                  r_count <= 2'd2;
               end else begin
                  // full: the controller never pushes here, drop it
                  r_count <= r_count;
               end
            end
            2'b01: begin
               r_pc0   <= r_pc1;
               r_inst0 <= r_inst1;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               // occupancy unchanged; new entry lands behind whatever remains
               if (r_count == 2'd1) begin
                  r_pc0   <= i_push_pc;
                  r_inst0 <= i_push_inst;
               end else begin
                  r_pc0   <= r_pc1;
                  r_inst0 <= r_inst1;
                  r_pc1   <= i_push_pc;
                  r_inst1 <= i_push_inst;
               end
            end
            default: begin
               r_count <= r_count;
            end
         endcase
      end
   end

   assign o_head_pc   = r_pc0;
   assign o_head_inst = r_inst0;
   assign o_valid     = (r_count != 2'd0);
   assign o_count     = r_count;

endmodule : fetch_buf

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch sequencer. Owns the PC, issues one-outstanding req/ack
// reads to instruction memory, buffers responses in a 2-entry prefetch queue
// and presents the head to decode. Handles decode stalls and branch
// redirects, discarding the in-flight response that a redirect makes stale.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall_i           decode cannot take the head this cycle
//   branch_i          1-cycle redirect pulse, target in branch_target_i
//   branch_target_i   redirect address (low two bits ignored)
//   mem_req_o         read request (registered)
//   mem_addr_o        read address (registered, held until ack)
//   mem_ack_i         transfer completes on an edge with req & ack
//   mem_data_i        read data, valid with mem_ack_i
//   inst_o, pc_o      head-of-queue instruction and its PC
//   inst_valid_o      queue not empty; popped when inst_valid_o & !stall_i
// -----------------------------------------------------------------------------
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int              ADDR_W   = FC_ADDR_W,
   parameter int              DATA_W   = FC_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FC_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              branch_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              inst_valid_o
);

   // Next sequential PC; wraps silently at the top of the address space
   function automatic logic [ADDR_W-1:0] pc_plus4(input logic [ADDR_W-1:0] pc);
      return pc + {{(ADDR_W-3){1'b0}}, 3'b100};
   endfunction

   fetch_state_t      r_state;
   logic              r_mem_req;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_fetch_pc;

   logic [ADDR_W-1:0] w_target;
   logic [ADDR_W-1:0] w_redirect_pc;
   logic              w_push;
   logic              w_pop;
   logic              w_flush;
   logic              w_valid;
   logic [1:0]        w_count;
   logic [1:0]        w_count_next;

   // Word-align the redirect target
   assign w_target = branch_target_i & ~{{(ADDR_W-2){1'b0}}, 2'b11};

   // Queue control: push only a non-stale response, flush on any redirect
   always_comb begin
      w_push        = 1'b0;
      w_flush       = 1'b0;
      w_pop         = w_valid & ~stall_i;
      w_redirect_pc = r_fetch_pc;
      if (r_state == S_BOOT) begin
         w_push  = 1'b0;
         w_flush = 1'b0;
      end else begin
         w_push  = (r_state == S_REQ) & mem_ack_i & ~branch_i;
         w_flush = branch_i;
      end
      // latest branch wins when a cancelled response returns the same cycle
      if (branch_i) begin
         w_redirect_pc = w_target;
      end else begin
         w_redirect_pc = r_fetch_pc;
      end
      w_count_next = w_count + {1'b0, w_push} - {1'b0, w_pop};
   end

   // Fetch FSM: state, request, request address and next fetch PC
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_BOOT;
         r_mem_req  <= 1'b0;
         r_addr     <= RESET_PC;
         r_fetch_pc <= RESET_PC;
      end else begin
         case (r_state)
            S_BOOT: begin
               r_state    <= S_REQ;
               r_mem_req  <= 1'b1;
               r_addr     <= RESET_PC;
               r_fetch_pc <= RESET_PC;
            end
            S_REQ: begin
               if (branch_i && mem_ack_i) begin
                  // response is stale; restart immediately at the target
                  r_addr     <= w_target;
                  r_fetch_pc <= w_target;
               end else if (branch_i) begin
                  // request must stay up unchanged until its ack arrives
                  r_fetch_pc <= w_target;
                  r_state    <= S_CANCEL;
               end else if (mem_ack_i) begin
                  r_fetch_pc <= pc_plus4(r_addr);
                  if (w_count_next < 2'd2) begin
                     r_addr <= pc_plus4(r_addr);
                  end else begin
                     r_state   <= S_IDLE;
                     r_mem_req <= 1'b0;
                  end
               end else begin
                  r_state <= S_REQ;
               end
            end
            S_IDLE: begin
               if (branch_i) begin
                  r_addr     <= w_target;
                  r_fetch_pc <= w_target;
                  r_state    <= S_REQ;
                  r_mem_req  <= 1'b1;
               end else if (w_pop) begin
                  r_addr    <= r_fetch_pc;
                  r_state   <= S_REQ;
                  r_mem_req <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CANCEL: begin
               if (mem_ack_i) begin
                  r_addr     <= w_redirect_pc;
                  r_fetch_pc <= w_redirect_pc;
                  r_state    <= S_REQ;
               end else if (branch_i) begin
                  r_fetch_pc <= w_target;
               end else begin
                  r_state <= S_CANCEL;
               end
            end
            default: begin
               r_state   <= S_BOOT;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   fetch_buf #(
      .AW (ADDR_W),
      .DW (DATA_W)
   ) u_buf (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_pc   (r_addr),
      .i_push_inst (mem_data_i),
      .i_pop       (w_pop),
      .i_flush     (w_flush),
      .o_head_pc   (pc_o),
      .o_head_inst (inst_o),
      .o_valid     (w_valid),
      .o_count     (w_count)
   );

   assign mem_req_o    = r_mem_req;
   assign mem_addr_o   = r_addr;
   assign inst_valid_o = w_valid;

endmodule : fetch_ctrl
